// File: rtl/perm_lane_buf.sv
// Lane-staging buffer: collects 25-lane Keccak states into NBANK banks and replays them framed by firstout.
// Define PERM_FRAME_CHECK_EN to add the frame_err / frame_err_cnt framing monitor.
module perm_lane_buf #(
   parameter int LANE_W    = 64,
   parameter int NBANK     = 2,
   parameter int OUT_ORDER = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pushin,
   input  logic              firstin,
   input  logic [LANE_W-1:0] din,
   output logic              stopin,
   output logic              pushout,
   output logic              firstout,
   output logic [LANE_W-1:0] dout,
   input  logic              stopout
`ifdef PERM_FRAME_CHECK_EN
   ,
   output logic              frame_err,
   output logic [7:0]        frame_err_cnt
`endif
);

   localparam int BW = $clog2(NBANK);
   localparam int CW = $clog2(NBANK + 1);
   localparam logic [4:0] LAST = 5'd24;

   typedef enum logic {WR_HUNT, WR_FILL} wr_st_t;
   typedef enum logic {RD_IDLE, RD_DRAIN} rd_st_t;

   logic [LANE_W-1:0] r_mem [NBANK][25];
   logic [NBANK-1:0]  r_full;
   logic [CW-1:0]     r_full_cnt;
   logic              r_stopin;
   wr_st_t            r_wr_st;
   logic [4:0]        r_wr_idx;
   logic [BW-1:0]     r_wr_bank;
   rd_st_t            r_rd_st;
   logic [4:0]        r_rd_idx;
   logic [BW-1:0]     r_rd_bank;
   logic              r_pushout;
   logic              r_firstout;
   logic [LANE_W-1:0] r_dout;

   logic              w_acc;
   logic              w_store;
   logic [4:0]        w_wr_addr;
   logic              w_fill;
   logic              w_consume;
   logic              w_free;
   logic [BW-1:0]     w_wr_bank_nxt;
   logic [BW-1:0]     w_rd_bank_nxt;
   logic              w_next_full;
   logic [CW-1:0]     w_full_cnt_nxt;
   logic [BW-1:0]     w_ld_bank;
   logic [4:0]        w_ld_idx;
   logic [LANE_W-1:0] w_ld_dat;

   function automatic logic [4:0] f_map(input logic [4:0] i);
      logic [4:0] q;
      logic [4:0] r;
      q = i / 5'd5;
      r = i % 5'd5;
      if (OUT_ORDER == 1) return r * 5'd5 + q;
      return i;
   endfunction

   assign w_acc          = pushin && !r_stopin;
   assign w_store        = w_acc && (firstin || r_wr_st == WR_FILL);
   assign w_wr_addr      = firstin ? 5'd0 : r_wr_idx;
   assign w_fill         = w_acc && !firstin && r_wr_st == WR_FILL && r_wr_idx == LAST;
   assign w_consume      = r_pushout && !stopout;
   assign w_free         = w_consume && r_rd_idx == LAST;
   assign w_wr_bank_nxt  = (r_wr_bank == BW'(NBANK - 1)) ? '0 : r_wr_bank + 1'b1;
   assign w_rd_bank_nxt  = (r_rd_bank == BW'(NBANK - 1)) ? '0 : r_rd_bank + 1'b1;
   // A bank completing on the same edge as the drain ends still counts, so no bubble appears.
   assign w_next_full    = r_full[w_rd_bank_nxt] || (w_fill && r_wr_bank == w_rd_bank_nxt);
   assign w_full_cnt_nxt = r_full_cnt + CW'(w_fill) - CW'(w_free);

   always_comb begin
      w_ld_bank = r_rd_bank;
      w_ld_idx  = 5'd0;
      if (r_rd_st == RD_DRAIN) begin
         if (r_rd_idx == LAST) w_ld_bank = w_rd_bank_nxt;
         else                  w_ld_idx  = r_rd_idx + 5'd1;
      end
   end
   assign w_ld_dat = r_mem[w_ld_bank][f_map(w_ld_idx)];

   always_ff @(posedge clk) begin
      if (w_store) r_mem[r_wr_bank][w_wr_addr] <= din;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_st    <= WR_HUNT;
         r_wr_idx   <= 5'd0;
         r_wr_bank  <= '0;
         r_full     <= '0;
         r_full_cnt <= '0;
         r_stopin   <= 1'b0;
      end else begin
         r_full_cnt <= w_full_cnt_nxt;
         r_stopin   <= (w_full_cnt_nxt == CW'(NBANK));
         if (w_fill) r_full[r_wr_bank] <= 1'b1;
         if (w_free) r_full[r_rd_bank] <= 1'b0;
         if (w_acc) begin
            if (firstin) begin
               r_wr_st  <= WR_FILL;
               r_wr_idx <= 5'd1;
            end else if (r_wr_st == WR_FILL) begin
               if (r_wr_idx == LAST) begin
                  r_wr_st   <= WR_HUNT;
                  r_wr_idx  <= 5'd0;
                  r_wr_bank <= w_wr_bank_nxt;
               end else begin
                  r_wr_idx <= r_wr_idx + 5'd1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rd_st    <= RD_IDLE;
         r_rd_idx   <= 5'd0;
         r_rd_bank  <= '0;
         r_pushout  <= 1'b0;
         r_firstout <= 1'b0;
         r_dout     <= '0;
      end else begin
         case (r_rd_st)
            RD_IDLE: begin
               if (r_full[r_rd_bank]) begin
                  r_rd_st    <= RD_DRAIN;
                  r_rd_idx   <= 5'd0;
                  r_pushout  <= 1'b1;
                  r_firstout <= 1'b1;
                  r_dout     <= w_ld_dat;
               end
            end
            RD_DRAIN: begin
               if (w_consume) begin
                  if (r_rd_idx == LAST) begin
                     r_rd_bank <= w_rd_bank_nxt;
                     r_rd_idx  <= 5'd0;
                     if (w_next_full) begin
                        r_firstout <= 1'b1;
                        r_dout     <= w_ld_dat;
                     end else begin
                        r_rd_st    <= RD_IDLE;
                        r_pushout  <= 1'b0;
                        r_firstout <= 1'b0;
                     end
                  end else begin
                     r_rd_idx   <= r_rd_idx + 5'd1;
                     r_firstout <= 1'b0;
                     r_dout     <= w_ld_dat;
                  end
               end
            end
            default: r_rd_st <= RD_IDLE;
         endcase
      end
   end

   assign stopin   = r_stopin;
   assign pushout  = r_pushout;
   assign firstout = r_firstout;
   assign dout     = r_dout;

`ifdef PERM_FRAME_CHECK_EN
   logic       w_ferr;
   logic       r_frame_err;
   logic [7:0] r_frame_err_cnt;

   assign w_ferr = w_acc && ((firstin && r_wr_st == WR_FILL) || (!firstin && r_wr_st == WR_HUNT));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_frame_err     <= 1'b0;
         r_frame_err_cnt <= 8'd0;
      end else begin
         r_frame_err <= w_ferr;
         if (w_ferr && r_frame_err_cnt != 8'hFF) r_frame_err_cnt <= r_frame_err_cnt + 8'd1;
      end
   end

   assign frame_err     = r_frame_err;
   assign frame_err_cnt = r_frame_err_cnt;
`endif

endmodule

// File: tb/tb_perm_lane_buf.sv
// Bench for perm_lane_buf: directed table plus multi-cycle sequences, and a randomized scoreboard run.
module tb_perm_lane_buf;

   logic        clk = 1'b0;
   logic        rst;
   logic        a_pushin, a_firstin, a_stopout;
   logic [63:0] a_din;
   logic        a_stopin, a_pushout, a_firstout;
   logic [63:0] a_dout;
   logic        b_stopin, b_pushout, b_firstout;
   logic [63:0] b_dout;
   logic        c_pushin, c_firstin, c_stopout;
   logic [15:0] c_din;
   logic        c_stopin, c_pushout, c_firstout;
   logic [15:0] c_dout;
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

`ifdef PERM_FRAME_CHECK_EN
   logic       a_ferr, b_ferr, c_ferr;
   logic [7:0] a_fcnt, b_fcnt, c_fcnt;
   int         err_pulses = 0;
   always @(negedge clk) if (a_ferr) err_pulses++;
`endif

   perm_lane_buf #(.LANE_W(64), .NBANK(2), .OUT_ORDER(0)) u_a (
      .clk(clk), .reset(rst), .pushin(a_pushin), .firstin(a_firstin), .din(a_din),
      .stopin(a_stopin), .pushout(a_pushout), .firstout(a_firstout), .dout(a_dout),
      .stopout(a_stopout)
`ifdef PERM_FRAME_CHECK_EN
      , .frame_err(a_ferr), .frame_err_cnt(a_fcnt)
`endif
   );

   perm_lane_buf #(.LANE_W(64), .NBANK(2), .OUT_ORDER(1)) u_b (
      .clk(clk), .reset(rst), .pushin(a_pushin), .firstin(a_firstin), .din(a_din),
      .stopin(b_stopin), .pushout(b_pushout), .firstout(b_firstout), .dout(b_dout),
      .stopout(a_stopout)
`ifdef PERM_FRAME_CHECK_EN
      , .frame_err(b_ferr), .frame_err_cnt(b_fcnt)
`endif
   );

   perm_lane_buf #(.LANE_W(16), .NBANK(3), .OUT_ORDER(0)) u_c (
      .clk(clk), .reset(rst), .pushin(c_pushin), .firstin(c_firstin), .din(c_din),
      .stopin(c_stopin), .pushout(c_pushout), .firstout(c_firstout), .dout(c_dout),
      .stopout(c_stopout)
`ifdef PERM_FRAME_CHECK_EN
      , .frame_err(c_ferr), .frame_err_cnt(c_fcnt)
`endif
   );

   typedef struct {
      logic        pushin;
      logic        firstin;
      logic [63:0] din;
      logic        exp_stopin;
      logic        exp_pushout;
      logic        exp_firstout;
      logic [63:0] exp_dout_a;
      logic [63:0] exp_dout_b;
   } vec_t;

   vec_t tbl[51];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Drives one lane on the A/B inputs and waits (bounded) until it is accepted.
   task automatic push_lane(input logic f, input logic [63:0] d);
      logic acc;
      logic done;
      done = 1'b0;
      a_pushin  = 1'b1;
      a_firstin = f;
      a_din     = d;
      for (int g = 0; g < 200 && !done; g++) begin
         acc = !a_stopin;
         step();
         if (acc) done = 1'b1;
      end
      chk("push_accept", done, 1'b1);
      a_pushin  = 1'b0;
      a_firstin = 1'b0;
   endtask

   task automatic collect(input string nm, input int base, input int num);
      int cnt;
      cnt = 0;
      for (int g = 0; g < 200 && cnt < num; g++) begin
         if (a_pushout) begin
            chk({nm, "_dout"}, a_dout, 64'(base + cnt));
            chk({nm, "_first"}, a_firstout, cnt == 0);
            cnt++;
         end
         step();
      end
      chk({nm, "_count"}, cnt, num);
      chk({nm, "_end_pushout"}, a_pushout, 1'b0);
   endtask

   initial begin
      int n, outs, bubbles, idle_push, j;
      logic acc, cons;
      logic [15:0] q[$];
      logic [15:0] e16;
      int frames, lane, fo_cnt;

      rst = 1'b1;
      a_pushin = 0; a_firstin = 0; a_din = '0; a_stopout = 0;
      c_pushin = 0; c_firstin = 0; c_din = '0; c_stopout = 0;
      step();
      step();
      chk("rst_stopin", a_stopin, 1'b0);
      chk("rst_pushout", a_pushout, 1'b0);
      chk("rst_firstout", a_firstout, 1'b0);
      chk("rst_dout", a_dout, 64'd0);
      chk("rst_b_pushout", b_pushout, 1'b0);
      chk("rst_c_pushout", c_pushout, 1'b0);
      chk("rst_c_stopin", c_stopin, 1'b0);
      rst = 1'b0;

      // One frame din=i; out lanes appear from the second edge after lane 24 is accepted.
      for (int k = 0; k < 51; k++) begin
         j = k - 25;
         tbl[k].pushin       = (k < 25);
         tbl[k].firstin      = (k == 0);
         tbl[k].din          = (k < 25) ? 64'(k) : 64'd0;
         tbl[k].exp_stopin   = 1'b0;
         tbl[k].exp_pushout  = (k >= 25 && k <= 49);
         tbl[k].exp_firstout = (k == 25);
         tbl[k].exp_dout_a   = 64'(j);
         tbl[k].exp_dout_b   = 64'((j % 5) * 5 + j / 5);
      end
      for (int k = 0; k < 51; k++) begin
         a_pushin  = tbl[k].pushin;
         a_firstin = tbl[k].firstin;
         a_din     = tbl[k].din;
         step();
         chk("t1_stopin", a_stopin, tbl[k].exp_stopin);
         chk("t1_pushout", a_pushout, tbl[k].exp_pushout);
         chk("t3_pushout", b_pushout, tbl[k].exp_pushout);
         if (tbl[k].exp_pushout) begin
            chk("t1_firstout", a_firstout, tbl[k].exp_firstout);
            chk("t1_dout", a_dout, tbl[k].exp_dout_a);
            chk("t3_firstout", b_firstout, tbl[k].exp_firstout);
            chk("t3_dout", b_dout, tbl[k].exp_dout_b);
         end
      end

      // Four frames against a stalled sink, then release.
      a_stopout = 1'b1;
      n = 0;
      for (int g = 0; g < 300 && !a_stopin && n < 100; g++) begin
         a_pushin = 1'b1; a_firstin = (n % 25 == 0); a_din = 64'(100 + n);
         step();
         n++;
      end
      chk("t2_accepted_at_stop", n, 50);
      for (int g = 0; g < 4; g++) begin
         step();
         chk("t2_hold_stopin", a_stopin, 1'b1);
         chk("t2_hold_pushout", a_pushout, 1'b1);
         chk("t2_hold_firstout", a_firstout, 1'b1);
         chk("t2_hold_dout", a_dout, 64'd100);
      end
      a_stopout = 1'b0;
      outs = 0;
      bubbles = 0;
      for (int g = 0; g < 400 && outs < 100; g++) begin
         a_pushin = (n < 100); a_firstin = (n % 25 == 0) && (n < 100); a_din = 64'(100 + n);
         acc = a_pushin && !a_stopin;
         if (a_pushout) begin
            chk("t2_dout", a_dout, 64'(100 + outs));
            outs++;
         end else begin
            bubbles++;
         end
         step();
         if (acc) n++;
      end
      a_pushin = 1'b0; a_firstin = 1'b0;
      chk("t2_out_count", outs, 100);
      chk("t2_in_count", n, 100);
      chk("t2_bubbles", bubbles, 0);
      chk("t2_end_pushout", a_pushout, 1'b0);

      // Early restart: the second firstin starts the frame over.
      for (int i = 0; i < 10; i++) push_lane(i == 0, 64'(200 + i));
      for (int i = 0; i < 25; i++) push_lane(i == 0, 64'(300 + i));
      collect("t4", 300, 25);
`ifdef PERM_FRAME_CHECK_EN
      chk("t4_err_pulses", err_pulses, 1);
      chk("t4_err_cnt", a_fcnt, 8'd1);
`endif

      // Reset in the middle of frame 2 while frame 1 drains.
      for (int i = 0; i < 25; i++) push_lane(i == 0, 64'(400 + i));
      for (int i = 0; i < 12; i++) push_lane(i == 0, 64'(500 + i));
      chk("t5_pre_pushout", a_pushout, 1'b1);
      a_pushin = 1'b1; a_din = 64'd512; rst = 1'b1;
      step();
      rst = 1'b0; a_pushin = 1'b0;
      chk("t5_rst_pushout", a_pushout, 1'b0);
      chk("t5_rst_firstout", a_firstout, 1'b0);
      chk("t5_rst_dout", a_dout, 64'd0);
      chk("t5_rst_stopin", a_stopin, 1'b0);
      for (int i = 13; i < 25; i++) push_lane(1'b0, 64'(500 + i));
      idle_push = 0;
      for (int g = 0; g < 30; g++) begin
         if (a_pushout) idle_push++;
         step();
      end
      chk("t5_no_output", idle_push, 0);
      for (int i = 0; i < 25; i++) push_lane(i == 0, 64'(600 + i));
      collect("t5_new", 600, 25);

      // Randomized traffic on the 16-bit, 3-bank instance.
      frames = 0; lane = 0; fo_cnt = 0; outs = 0;
      for (int cyc = 0; cyc < 80000 && (frames < 1000 || q.size() > 0); cyc++) begin
         if (frames < 1000) begin
            c_pushin  = ($urandom_range(9) < 7);
            c_firstin = (lane == 0);
            c_din     = 16'($urandom);
            c_stopout = ($urandom_range(9) < 3);
         end else begin
            c_pushin  = 1'b0;
            c_firstin = 1'b0;
            c_stopout = 1'b0;
         end
         acc  = c_pushin && !c_stopin;
         cons = c_pushout && !c_stopout;
         if (cons) begin
            if (q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL t6_underflow: output lane with empty scoreboard");
            end else begin
               e16 = q.pop_front();
               chk("t6_dout", c_dout, e16);
            end
            chk("t6_firstout", c_firstout, (outs % 25) == 0);
            if (c_firstout) fo_cnt++;
            outs++;
         end
         if (acc) begin
            q.push_back(c_din);
            if (lane == 24) begin
               lane = 0;
               frames++;
            end else begin
               lane++;
            end
         end
         step();
      end
      chk("t6_frames_in", frames, 1000);
      chk("t6_firstout_cnt", fo_cnt, 1000);
      chk("t6_left", q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
